// File: rtl/regfile_mp.sv
// Multi-port register file: registered reads with same-edge write bypass,
// lowest-index write-port priority with conflict pulses, and a per-register
// busy scoreboard set on issue and cleared on winning writeback.
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   RADDR,
  output logic [NUM_RD*DATA_WIDTH-1:0]   RDATA,
  output logic [NUM_RD-1:0]              RBUSY,
  input  logic [NUM_WR-1:0]              WE,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   WADDR,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   WDATA,
  input  logic                           ISSUE_EN,
  input  logic [ADDR_WIDTH-1:0]          ISSUE_ADDR,
  output logic [NUM_WR-1:0]              WR_CONFLICT
);

  localparam int DEPTH   = 2**ADDR_WIDTH;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;

  logic [ADDR_WIDTH-1:0] waddr_a [NUM_WR];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_WR];
  logic [ADDR_WIDTH-1:0] raddr_a [NUM_RD];

  logic [NUM_WR-1:0]     wr_eff;
  logic [NUM_WR-1:0]     wr_win;
  logic                  issue_eff;

  logic [NUM_RD*DATA_WIDTH-1:0] rdata_d;
  logic [NUM_RD-1:0]            rbusy_d;

  // Unpack the flat port buses into per-port addresses and data.
  always_comb begin
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      waddr_a[j] = WADDR[j*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_a[j] = WDATA[j*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      raddr_a[i] = RADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Effective writes exclude the hardwired zero register; a port wins unless
  // a lower-index effective port targets the same address.
  always_comb begin
    wr_eff = '0;
    wr_win = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wr_eff[j] = WE[j] && !(ZERO_EN && (waddr_a[j] == '0));
    end
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wr_win[j] = wr_eff[j];
      for (int unsigned k = 0; k < j; k++) begin
        if (wr_eff[k] && (waddr_a[k] == waddr_a[j])) begin
          wr_win[j] = 1'b0;
        end
      end
    end
  end

  // Issue marks the destination busy unless it is the hardwired zero register.
  always_comb begin
    issue_eff = ISSUE_EN && !(ZERO_EN && (ISSUE_ADDR == '0));
  end

  // Next busy state: winning writes clear, then issue sets so a newer
  // producer issued on the same edge stays outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_win[j]) begin
        busy_d[waddr_a[j]] = 1'b0;
      end
    end
    if (issue_eff) begin
      busy_d[ISSUE_ADDR] = 1'b1;
    end
  end

  // Read data with write-first bypass; at most one winner per address, so
  // the order of the bypass scan does not matter.
  always_comb begin
    rdata_d = '0;
    rbusy_d = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[raddr_a[i]];
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_win[j] && (waddr_a[j] == raddr_a[i])) begin
          rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = wdata_a[j];
        end
      end
      rbusy_d[i] = busy_d[raddr_a[i]];
      if (ZERO_EN && (raddr_a[i] == '0)) begin
        rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        rbusy_d[i] = 1'b0;
      end
    end
  end

  // Register array: winning write ports update storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_win[j]) begin
          regs_q[waddr_a[j]] <= wdata_a[j];
        end
      end
    end
  end

  // Scoreboard, registered read outputs and conflict pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      RDATA       <= '0;
      RBUSY       <= '0;
      WR_CONFLICT <= '0;
    end else begin
      busy_q      <= busy_d;
      RDATA       <= rdata_d;
      RBUSY       <= rbusy_d;
      WR_CONFLICT <= wr_eff & ~wr_win;
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the superscalar/dual-issue datapath.
- Configurable read-port count, write-port count, width and depth.
- Registered reads with same-edge write-to-read bypass; deterministic write-port priority with conflict reporting.
- Per-register busy scoreboard; feeds operand-fetch stage, accepts writeback from all execution lanes.

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 32, register data width
NUM_RD, 4, number of read ports (>=1)
NUM_WR, 2, number of write ports (>=1)
ZERO_REG, 1, 1 = index 0 hardwired to zero and never busy; 0 = index 0 is an ordinary register

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous reset, active low
RADDR  in  NUM_RD*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
RDATA  out  NUM_RD*DATA_WIDTH  registered read data, same packing
RBUSY  out  NUM_RD  registered busy flag of the register read on port i
WE  in  NUM_WR  write enables
WADDR  in  NUM_WR*ADDR_WIDTH  write addresses
WDATA  in  NUM_WR*DATA_WIDTH  write data
ISSUE_EN  in  1  mark ISSUE_ADDR busy (producer issued)
ISSUE_ADDR  in  ADDR_WIDTH  destination register being issued
WR_CONFLICT  out  NUM_WR  registered 1-cycle pulse: write port j lost priority and was dropped

Behaviour:
- Reset (rst_n low, asynchronous): every register = 0, every busy bit = 0, RDATA = 0, RBUSY = 0, WR_CONFLICT = 0. Held while rst_n low; first update on the first rising edge after deassertion. Reset mid-operation discards pending writes/issues of that cycle.
- Writes: single rising-edge write phase (no negedge writes). Port j is effective when WE[j] = 1 and not (ZERO_REG and WADDR[j] = 0).
- Priority: several effective ports targeting the same address -> lowest index wins. Each losing port j gets WR_CONFLICT[j] = 1 for exactly the following cycle. Different addresses on all ports -> all write in parallel, no conflict.
- Writes to index 0 with ZERO_REG = 1: silently ignored; no conflict flagged.
- Reads: latency 1. RADDR sampled at edge N; RDATA valid from edge N until edge N+1.
- Bypass (write-first): RDATA after edge N = winning WDATA if an effective write to the same address occurs at edge N, else stored value.
- Zero read: ZERO_REG = 1 and RADDR = 0 -> RDATA = 0, RBUSY = 0.
- Any number of read ports may address the same register; no read-port conflicts.
- Busy scoreboard, per register, updated at each edge:
  - ISSUE_EN = 1 (and not ZERO_REG with ISSUE_ADDR = 0) -> busy[ISSUE_ADDR] set.
  - Effective winning write to address a -> busy[a] cleared.
  - Set and clear on the same address at the same edge -> set wins (newer producer outstanding).
  - Losing writes never clear busy.
- RBUSY[i] after edge N = busy state of the sampled address after that edge's updates, consistent with the bypassed RDATA.
- No other state; block has no stall or ready handshake; all inputs assumed valid every cycle.

Test Plan:
1. Reset: rst_n low mid-run with registers non-zero -> RDATA = 0, RBUSY = 0 and WR_CONFLICT = 0 immediately (before next edge); after release, reading x5 returns 0.
2. Basic write/read: WE[0] = 1, WADDR[0] = 5, WDATA[0] = 0xDEADBEEF at edge 1; RADDR[0] = 5 at edge 2 -> RDATA[0] = 0xDEADBEEF after edge 2.
3. Bypass: same edge WE[1] = 1, WADDR[1] = 7, WDATA[1] = 0x12345678 and RADDR[2] = 7 -> RDATA[2] = 0x12345678 after that edge; with WE deasserted, RADDR[2] = 8 returns its old value.
4. Write conflict: WE = 2'b11, both WADDR = 3, WDATA[0] = 0xAAAA0000, WDATA[1] = 0x0000BBBB -> x3 = 0xAAAA0000; WR_CONFLICT = 2'b10 for one cycle, then 2'b00.
5. Zero register: WE[0] = 1, WADDR[0] = 0, WDATA[0] = 0xFFFFFFFF; plus ISSUE_EN with ISSUE_ADDR = 0 -> reading x0 gives RDATA = 0, RBUSY = 0; WR_CONFLICT = 0.
6. Scoreboard: ISSUE_EN = 1 for x9 at edge 1 -> RBUSY = 1 reading x9. Write x9 = 0x55 together with ISSUE_EN for x9 at edge 3 -> RBUSY stays 1 with RDATA = 0x55. Write x9 = 0x66 alone at edge 4 -> RBUSY = 0 with RDATA = 0x66.
